// File: rtl/rv_conv_lane_packer.sv
// rv_conv_lane_packer: packs N streamed elements into one lane vector for the adder tree.
// Optional RV_PACKER_STATS_EN adds consumed-group and padded-lane counters.
module rv_conv_lane_packer #(
    parameter int N     = 4,
    parameter int DATAW = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATAW-1:0]       in_data,
    input  logic                   in_last,
    output logic                   out_en,
    input  logic                   out_ready,
    output logic [N*DATAW-1:0]     out_data,
    output logic [$clog2(N+1)-1:0] out_count,
    output logic                   out_last
`ifdef RV_PACKER_STATS_EN
    ,
    output logic [31:0]            stat_groups,
    output logic [31:0]            stat_pad_lanes
`endif
);
    localparam int CW  = $clog2(N);
    localparam int OCW = $clog2(N+1);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]         state;
    logic [CW-1:0]      fill_cnt;
    logic [N*DATAW-1:0] lanes;
    logic [N*DATAW-1:0] vec;
    logic               acc;
    logic               close;
    logic               consume;

    assign out_en   = state == FULL;
    assign in_ready = state == EMPTY || out_ready;
    assign acc      = in_valid && in_ready;
    assign close    = acc && (in_last || fill_cnt == CW'(N-1));
    assign consume  = out_en && out_ready;

    // Unfilled lanes are already zero, so the closing vector is naturally padded.
    always_comb begin
        vec = lanes;
        vec[int'(fill_cnt)*DATAW +: DATAW] = in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            fill_cnt  <= '0;
            lanes     <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
        end else if (close) begin
            state     <= FULL;
            fill_cnt  <= '0;
            lanes     <= '0;
            out_data  <= vec;
            out_count <= OCW'(fill_cnt) + OCW'(1);
            out_last  <= in_last;
        end else begin
            if (acc) begin
                lanes    <= vec;
                fill_cnt <= fill_cnt + 1'b1;
            end
            if (consume)
                state <= EMPTY;
        end
    end

`ifdef RV_PACKER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_groups    <= '0;
            stat_pad_lanes <= '0;
        end else if (consume) begin
            stat_groups    <= stat_groups + 32'd1;
            stat_pad_lanes <= stat_pad_lanes + 32'(N) - 32'(out_count);
        end
    end
`endif
endmodule

// File: tb/tb_rv_conv_lane_packer.sv
// tb_rv_conv_lane_packer: queue-based reference model plus directed literal checks.
module tb_rv_conv_lane_packer;
    localparam int N = 4;
    localparam int DATAW = 8;
    localparam int OCW = $clog2(N+1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [DATAW-1:0] in_data = '0;
    logic in_last = 1'b0;
    logic out_en;
    logic out_ready = 1'b1;
    logic [N*DATAW-1:0] out_data;
    logic [OCW-1:0] out_count;
    logic out_last;
`ifdef RV_PACKER_STATS_EN
    logic [31:0] stat_groups;
    logic [31:0] stat_pad_lanes;
`endif

    rv_conv_lane_packer #(.N(N), .DATAW(DATAW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_en(out_en), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count), .out_last(out_last)
`ifdef RV_PACKER_STATS_EN
        , .stat_groups(stat_groups), .stat_pad_lanes(stat_pad_lanes)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: elements gathered in a queue, group emitted when N collected or last seen.
    logic [DATAW-1:0] grp[$];
    logic m_full = 1'b0;
    logic [N*DATAW-1:0] m_vec = '0;
    int m_cnt = 0;
    logic m_last = 1'b0;
    longint m_groups = 0;
    longint m_pad = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            grp.delete();
            m_full = 1'b0;
            m_vec = '0;
            m_cnt = 0;
            m_last = 1'b0;
            m_groups = 0;
            m_pad = 0;
        end else begin
            automatic bit acc = in_valid && (!m_full || out_ready);
            automatic bit cons = m_full && out_ready;
            automatic bit closed = 1'b0;
            if (cons) begin
                m_groups++;
                m_pad += N - m_cnt;
            end
            if (acc) begin
                grp.push_back(in_data);
                if (grp.size() == N || in_last) begin
                    m_vec = '0;
                    for (int i = 0; i < grp.size(); i++)
                        m_vec[i*DATAW +: DATAW] = grp[i];
                    m_cnt = grp.size();
                    m_last = in_last;
                    grp.delete();
                    closed = 1'b1;
                end
            end
            if (closed) m_full = 1'b1;
            else if (cons) m_full = 1'b0;
        end
    end

    logic [N*DATAW-1:0] log_data[$];
    int log_cnt[$];
    logic log_last[$];

    always @(negedge clk) begin
        chk("in_ready", in_ready, !m_full || out_ready);
        chk("out_en", out_en, m_full);
        if (m_full) begin
            chk("out_data", out_data, m_vec);
            chk("out_count", out_count, m_cnt);
            chk("out_last", out_last, m_last);
        end
`ifdef RV_PACKER_STATS_EN
        chk("stat_groups", stat_groups, m_groups & 64'hFFFF_FFFF);
        chk("stat_pad_lanes", stat_pad_lanes, m_pad & 64'hFFFF_FFFF);
`endif
        if (out_en && out_ready && !reset) begin
            log_data.push_back(out_data);
            log_cnt.push_back(int'(out_count));
            log_last.push_back(out_last);
        end
    end

    task automatic send(input logic [DATAW-1:0] d, input logic l);
        int k;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        k = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 50) begin
                chk("send_timeout", 1'b1, 1'b0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = 8'h5A;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        chk("rst_out_en", out_en, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_count", out_count, '0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [N*DATAW-1:0] exp_data[9] = '{32'h04030201, 32'h08070605, 32'h00332211, 32'hB4B3B2B1,
                                       32'h000000D1, 32'hA4A3A2A1, 32'h54535251, 32'h00636261,
                                       32'h00000071};
    int exp_cnt[9] = '{4, 4, 3, 4, 1, 4, 4, 3, 1};
    logic exp_last[9] = '{0, 0, 1, 0, 1, 1, 0, 1, 1};

    initial begin
        #1;
        chk("init_out_en", out_en, 1'b0);
        chk("init_out_data", out_data, '0);
        chk("init_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        // Full groups back to back
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        idle(2);
        // Partial group closed by last
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 1);
        idle(2);
        // Backpressure then reload on the closing cycle
        send(8'hB1, 0); send(8'hB2, 0); send(8'hB3, 0); send(8'hB4, 0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hD1; in_last = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_out_data", out_data, 32'hB4B3B2B1);
        out_ready = 1'b1;
        send(8'hD1, 1);
        // Last on lane N-1
        send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0); send(8'hA4, 1);
        idle(3);
        // Reset with a held vector, then reset with a partial group
        send(8'hE1, 0); send(8'hE2, 0); send(8'hE3, 0); send(8'hE4, 0);
        out_ready = 1'b0;
        idle(3);
        pulse_reset();
        out_ready = 1'b1;
        send(8'hC1, 0); send(8'hC2, 0);
        idle(1);
        pulse_reset();
        send(8'h51, 0); send(8'h52, 0); send(8'h53, 0); send(8'h54, 0);
        send(8'h61, 0); send(8'h62, 0); send(8'h63, 1);
        send(8'h71, 1);
        idle(3);
        chk("log_size", log_data.size(), 9);
        for (int i = 0; i < 9 && i < log_data.size(); i++) begin
            chk($sformatf("vec%0d_data", i), log_data[i], exp_data[i]);
            chk($sformatf("vec%0d_count", i), log_cnt[i], exp_cnt[i]);
            chk($sformatf("vec%0d_last", i), log_last[i], exp_last[i]);
        end
`ifdef RV_PACKER_STATS_EN
        chk("lit_stat_groups", stat_groups, 32'd3);
        chk("lit_stat_pad", stat_pad_lanes, 32'd4);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
